// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered, flow-controlled driver for the 6-bit combinational ALU.
// Accepts one {f,x,n} operation plus two operands, drives the ALU from registers,
// waits SETTLE_CYCLES edges, captures the result and flags, and returns them over
// a valid/ready response channel.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = idle, combinational)
//   cmd_op, cmd_a, cmd_b           opcode {f,x,n} and operands
//   alu_in1, alu_in2, alu_f/x/n    registered drive to the ALU
//   alu_result, alu_co, alu_overf  ALU outputs sampled after the settle time
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_op             captured result and the opcode that produced it
//   rsp_zero, rsp_neg              result == 0, result sign bit
//   rsp_carry, rsp_overf           captured carry/overflow, only for opcodes 110/111
//   busy                           not idle (combinational)
//   op_count                       completed responses, wrapping
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic               alu_f,
  output logic               alu_x,
  output logic               alu_n,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_co,
  input  logic               alu_overf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [2:0]         rsp_op,
  output logic               rsp_zero,
  output logic               rsp_neg,
  output logic               rsp_carry,
  output logic               rsp_overf,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [SETTLE_W-1:0]  settle_cnt, settle_cnt_nxt;
  logic [WIDTH-1:0]     alu_in1_nxt, alu_in2_nxt;
  logic [2:0]           alu_op_nxt;
  logic                 rsp_valid_nxt;
  logic [WIDTH-1:0]     rsp_result_nxt;
  logic [2:0]           rsp_op_nxt;
  logic                 rsp_zero_nxt, rsp_neg_nxt, rsp_carry_nxt, rsp_overf_nxt;
  logic [COUNT_W-1:0]   op_count_nxt;
  logic                 flags_en;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Carry/overflow are only meaningful for the arithmetic opcodes 110 and 111.
  assign flags_en = alu_f & alu_x;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    alu_in1_nxt    = alu_in1;
    alu_in2_nxt    = alu_in2;
    alu_op_nxt     = {alu_f, alu_x, alu_n};
    rsp_valid_nxt  = rsp_valid;
    rsp_result_nxt = rsp_result;
    rsp_op_nxt     = rsp_op;
    rsp_zero_nxt   = rsp_zero;
    rsp_neg_nxt    = rsp_neg;
    rsp_carry_nxt  = rsp_carry;
    rsp_overf_nxt  = rsp_overf;
    op_count_nxt   = op_count;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          alu_in1_nxt    = cmd_a;
          alu_in2_nxt    = cmd_b;
          alu_op_nxt     = cmd_op;
          settle_cnt_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          // The drive registers still hold the accepted opcode, so they double as its latch.
          rsp_result_nxt = alu_result;
          rsp_op_nxt     = {alu_f, alu_x, alu_n};
          rsp_zero_nxt   = (alu_result == '0);
          rsp_neg_nxt    = alu_result[WIDTH-1];
          rsp_carry_nxt  = alu_co & flags_en;
          rsp_overf_nxt  = alu_overf & flags_en;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = RESP;
        end else begin
          settle_cnt_nxt = settle_cnt - SETTLE_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          op_count_nxt  = op_count + COUNT_W'(1);
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_f      <= 1'b0;
      alu_x      <= 1'b0;
      alu_n      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_overf  <= 1'b0;
      op_count   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      alu_in1    <= alu_in1_nxt;
      alu_in2    <= alu_in2_nxt;
      alu_f      <= alu_op_nxt[2];
      alu_x      <= alu_op_nxt[1];
      alu_n      <= alu_op_nxt[0];
      rsp_valid  <= rsp_valid_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_op     <= rsp_op_nxt;
      rsp_zero   <= rsp_zero_nxt;
      rsp_neg    <= rsp_neg_nxt;
      rsp_carry  <= rsp_carry_nxt;
      rsp_overf  <= rsp_overf_nxt;
      op_count   <= op_count_nxt;
    end
  end

endmodule
